// File: rtl/dccm_ctrl.sv
// dccm_ctrl: request controller in front of the single-read/single-write DCCM.
//
// Arbitrates between the LSU and a DMA requester (round-robin on conflict),
// maps byte addresses to DCCM word indices, returns load data one cycle after
// the handshake, and performs sub-word stores as a two-cycle read-modify-write.
//
// Build option:
//   DCCM_CTRL_DMA_EN  defined   -> DMA port live, round-robin arbitration.
//                     undefined -> dma_req_valid ignored, dma_* outputs tied 0,
//                                  LSU always granted in IDLE.
//
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   lsu_req_* / lsu_rsp_*       LSU request channel and load response
//   dma_req_* / dma_rsp_*       DMA request channel and load response
//   dccm_raddr, dccm_rvalid_in  DCCM read index / read enable
//   dccm_rdata, dccm_rvalid_out DCCM read data / valid (one cycle after read)
//   dccm_waddr, dccm_wen,
//   dccm_wdata                  DCCM write port
module dccm_ctrl #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 1024,
  parameter int TAG_W = 4,
  localparam int BW  = WIDTH / 8,
  localparam int AW  = $clog2(DEPTH * WIDTH / 8),
  localparam int IW  = $clog2(DEPTH),
  localparam int LSB = $clog2(BW)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             lsu_req_valid,
  output logic             lsu_req_ready,
  input  logic             lsu_req_we,
  input  logic [AW-1:0]    lsu_req_addr,
  input  logic [BW-1:0]    lsu_req_be,
  input  logic [WIDTH-1:0] lsu_req_wdata,
  input  logic [TAG_W-1:0] lsu_req_tag,
  output logic             lsu_rsp_valid,
  output logic [WIDTH-1:0] lsu_rsp_data,
  output logic [TAG_W-1:0] lsu_rsp_tag,
  input  logic             dma_req_valid,
  output logic             dma_req_ready,
  input  logic             dma_req_we,
  input  logic [AW-1:0]    dma_req_addr,
  input  logic [BW-1:0]    dma_req_be,
  input  logic [WIDTH-1:0] dma_req_wdata,
  input  logic [TAG_W-1:0] dma_req_tag,
  output logic             dma_rsp_valid,
  output logic [WIDTH-1:0] dma_rsp_data,
  output logic [TAG_W-1:0] dma_rsp_tag,
  output logic [IW-1:0]    dccm_raddr,
  output logic             dccm_rvalid_in,
  input  logic [WIDTH-1:0] dccm_rdata,
  input  logic             dccm_rvalid_out,
  output logic [IW-1:0]    dccm_waddr,
  output logic             dccm_wen,
  output logic [WIDTH-1:0] dccm_wdata
);

  typedef enum logic [1:0] {IDLE, RD, RMW} state_t;

  state_t           state_reg;
  logic             owner_reg;   // 1 = DMA issued the load in flight
  logic [TAG_W-1:0] tag_reg;
  logic [IW-1:0]    addr_reg;
  logic [BW-1:0]    be_reg;
  logic [WIDTH-1:0] wdata_reg;

  logic gnt_lsu, gnt_dma;

`ifdef DCCM_CTRL_DMA_EN
  logic ptr_reg;  // last granted requester, 1 = DMA

  // On conflict the requester that was not granted last time wins.
  assign gnt_lsu = lsu_req_valid & (~dma_req_valid | ptr_reg);
  assign gnt_dma = dma_req_valid & (~lsu_req_valid | ~ptr_reg);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_reg <= 1'b1;
    end else if (state_reg == IDLE && (gnt_lsu || gnt_dma)) begin
      ptr_reg <= gnt_dma;
    end
  end
`else
  assign gnt_lsu = lsu_req_valid;
  assign gnt_dma = 1'b0;
`endif

  // Fields of the granted request.
  logic             sel_we;
  logic [IW-1:0]    sel_idx;
  logic [BW-1:0]    sel_be;
  logic [WIDTH-1:0] sel_wdata;
  logic [TAG_W-1:0] sel_tag;

  assign sel_we    = gnt_dma ? dma_req_we               : lsu_req_we;
  assign sel_idx   = gnt_dma ? dma_req_addr[AW-1:LSB]   : lsu_req_addr[AW-1:LSB];
  assign sel_be    = gnt_dma ? dma_req_be               : lsu_req_be;
  assign sel_wdata = gnt_dma ? dma_req_wdata            : lsu_req_wdata;
  assign sel_tag   = gnt_dma ? dma_req_tag              : lsu_req_tag;

  logic hs, hs_load, hs_full, hs_part;
  assign hs      = ~rst & (state_reg == IDLE) & (gnt_lsu | gnt_dma);
  assign hs_load = hs & ~sel_we;
  assign hs_full = hs & sel_we & (&sel_be);
  assign hs_part = hs & sel_we & (|sel_be) & ~(&sel_be);
  // Stores with be == 0 complete the handshake but touch nothing.

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      owner_reg <= 1'b0;
      tag_reg   <= '0;
      addr_reg  <= '0;
      be_reg    <= '0;
      wdata_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (hs_load) begin
            tag_reg   <= sel_tag;
            owner_reg <= gnt_dma;
            state_reg <= RD;
          end else if (hs_part) begin
            addr_reg  <= sel_idx;
            be_reg    <= sel_be;
            wdata_reg <= sel_wdata;
            state_reg <= RMW;
          end
        end
        RD:      state_reg <= IDLE;
        RMW:     state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Byte-lane merge for the RMW write: new byte where enabled, old otherwise.
  logic [WIDTH-1:0] merged;
  genvar gi;
  generate
    for (gi = 0; gi < BW; gi++) begin : g_merge
      assign merged[gi*8 +: 8] = be_reg[gi] ? wdata_reg[gi*8 +: 8] : dccm_rdata[gi*8 +: 8];
    end
  endgenerate

  logic in_rmw, in_rd;
  assign in_rmw = ~rst & (state_reg == RMW);
  assign in_rd  = ~rst & (state_reg == RD) & dccm_rvalid_out;

  // DCCM ports; everything reads 0 while rst is high.
  assign dccm_rvalid_in = hs_load | hs_part;
  assign dccm_raddr     = (hs_load | hs_part) ? sel_idx : '0;
  assign dccm_wen       = hs_full | in_rmw;
  assign dccm_waddr     = in_rmw ? addr_reg : (hs_full ? sel_idx   : '0);
  assign dccm_wdata     = in_rmw ? merged   : (hs_full ? sel_wdata : '0);

  assign lsu_req_ready = hs & gnt_lsu;
  assign lsu_rsp_valid = in_rd & ~owner_reg;
  assign lsu_rsp_data  = lsu_rsp_valid ? dccm_rdata : '0;
  assign lsu_rsp_tag   = lsu_rsp_valid ? tag_reg    : '0;

`ifdef DCCM_CTRL_DMA_EN
  assign dma_req_ready = hs & gnt_dma;
  assign dma_rsp_valid = in_rd & owner_reg;
  assign dma_rsp_data  = dma_rsp_valid ? dccm_rdata : '0;
  assign dma_rsp_tag   = dma_rsp_valid ? tag_reg    : '0;

  // Byte-offset address bits have no function at word granularity.
  logic unused_bits;
  assign unused_bits = ^{lsu_req_addr, dma_req_addr};
`else
  assign dma_req_ready = 1'b0;
  assign dma_rsp_valid = 1'b0;
  assign dma_rsp_data  = '0;
  assign dma_rsp_tag   = '0;

  // DMA inputs and byte-offset address bits are intentionally unused here.
  logic unused_bits;
  assign unused_bits = ^{lsu_req_addr, dma_req_valid, dma_req_we, dma_req_addr,
                         dma_req_be, dma_req_wdata, dma_req_tag};
`endif

endmodule

// File: tb/tb_dccm_ctrl.sv
module tb_dccm_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        lsu_req_valid, lsu_req_ready, lsu_req_we;
  logic [11:0] lsu_req_addr;
  logic [3:0]  lsu_req_be;
  logic [31:0] lsu_req_wdata;
  logic [3:0]  lsu_req_tag;
  logic        lsu_rsp_valid;
  logic [31:0] lsu_rsp_data;
  logic [3:0]  lsu_rsp_tag;
  logic        dma_req_valid, dma_req_ready, dma_req_we;
  logic [11:0] dma_req_addr;
  logic [3:0]  dma_req_be;
  logic [31:0] dma_req_wdata;
  logic [3:0]  dma_req_tag;
  logic        dma_rsp_valid;
  logic [31:0] dma_rsp_data;
  logic [3:0]  dma_rsp_tag;
  logic [9:0]  dccm_raddr, dccm_waddr;
  logic        dccm_rvalid_in, dccm_rvalid_out, dccm_wen;
  logic [31:0] dccm_rdata, dccm_wdata;

  always #5 clk = ~clk;

  dccm_ctrl #(.WIDTH(32), .DEPTH(1024), .TAG_W(4)) dut (
    .clk(clk), .rst(rst),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready),
    .lsu_req_we(lsu_req_we), .lsu_req_addr(lsu_req_addr),
    .lsu_req_be(lsu_req_be), .lsu_req_wdata(lsu_req_wdata),
    .lsu_req_tag(lsu_req_tag), .lsu_rsp_valid(lsu_rsp_valid),
    .lsu_rsp_data(lsu_rsp_data), .lsu_rsp_tag(lsu_rsp_tag),
    .dma_req_valid(dma_req_valid), .dma_req_ready(dma_req_ready),
    .dma_req_we(dma_req_we), .dma_req_addr(dma_req_addr),
    .dma_req_be(dma_req_be), .dma_req_wdata(dma_req_wdata),
    .dma_req_tag(dma_req_tag), .dma_rsp_valid(dma_rsp_valid),
    .dma_rsp_data(dma_rsp_data), .dma_rsp_tag(dma_rsp_tag),
    .dccm_raddr(dccm_raddr), .dccm_rvalid_in(dccm_rvalid_in),
    .dccm_rdata(dccm_rdata), .dccm_rvalid_out(dccm_rvalid_out),
    .dccm_waddr(dccm_waddr), .dccm_wen(dccm_wen), .dccm_wdata(dccm_wdata)
  );

  // DCCM macro model: one-cycle read latency, write at the clock edge.
  logic [31:0] mem [0:1023];
  always @(posedge clk) begin
    if (dccm_wen) mem[dccm_waddr] <= dccm_wdata;
    dccm_rvalid_out <= dccm_rvalid_in;
    if (dccm_rvalid_in) dccm_rdata <= mem[dccm_raddr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  wire any_out = |{lsu_req_ready, lsu_rsp_valid, lsu_rsp_data, lsu_rsp_tag,
                   dma_req_ready, dma_rsp_valid, dma_rsp_data, dma_rsp_tag,
                   dccm_raddr, dccm_rvalid_in, dccm_waddr, dccm_wen, dccm_wdata};

  // Scoreboard: expected load responses per port.
  typedef struct {
    logic [31:0] data;
    logic [3:0]  tag;
    int          at_cyc;
  } rsp_t;
  rsp_t lsu_q[$];
  rsp_t dma_q[$];

  always @(negedge clk) begin
    rsp_t e;
    if (lsu_rsp_valid) begin
      if (lsu_q.size() == 0) chk("lsu_rsp_unexpected", 32'd1, 32'd0);
      else begin
        e = lsu_q.pop_front();
        chk("lsu_rsp_data", lsu_rsp_data, e.data);
        chk("lsu_rsp_tag", {28'd0, lsu_rsp_tag}, {28'd0, e.tag});
        chk("lsu_rsp_cycle", cyc, e.at_cyc);
        $display("rsp lsu data=%h tag=%0d cyc=%0d", lsu_rsp_data, lsu_rsp_tag, cyc);
      end
    end
    if (dma_rsp_valid) begin
      if (dma_q.size() == 0) chk("dma_rsp_unexpected", 32'd1, 32'd0);
      else begin
        e = dma_q.pop_front();
        chk("dma_rsp_data", dma_rsp_data, e.data);
        chk("dma_rsp_tag", {28'd0, dma_rsp_tag}, {28'd0, e.tag});
        chk("dma_rsp_cycle", cyc, e.at_cyc);
        $display("rsp dma data=%h tag=%0d cyc=%0d", dma_rsp_data, dma_rsp_tag, cyc);
      end
    end
  end

  typedef struct {
    logic        we;
    logic [11:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [3:0]  tag;
    logic        exp_wen;    // handshake-cycle write
    logic        exp_rd;     // handshake-cycle read
    logic [9:0]  exp_idx;
    logic [31:0] exp_wdata;  // full-store data or RMW merged word
    logic [31:0] exp_rdata;  // load response data
  } vec_t;

  vec_t vecs [11];

  task automatic do_txn(input int i, input vec_t v);
    bit got = 0;
    bit part;
    lsu_req_we = v.we; lsu_req_addr = v.addr; lsu_req_be = v.be;
    lsu_req_wdata = v.wdata; lsu_req_tag = v.tag; lsu_req_valid = 1'b1;
    for (int k = 0; k < 8 && !got; k++) begin
      @(negedge clk);
      if (lsu_req_ready) got = 1;
      else @(posedge clk);
    end
    if (!got) begin
      chk($sformatf("v%0d_ready_timeout", i), 32'd0, 32'd1);
      @(posedge clk); #1 lsu_req_valid = 1'b0;
      return;
    end
    chk($sformatf("v%0d_wen", i), {31'd0, dccm_wen}, {31'd0, v.exp_wen});
    chk($sformatf("v%0d_rvalid_in", i), {31'd0, dccm_rvalid_in}, {31'd0, v.exp_rd});
    chk($sformatf("v%0d_dma_ready", i), {31'd0, dma_req_ready}, 32'd0);
    if (v.exp_rd) chk($sformatf("v%0d_raddr", i), {22'd0, dccm_raddr}, {22'd0, v.exp_idx});
    if (v.exp_wen) begin
      chk($sformatf("v%0d_waddr", i), {22'd0, dccm_waddr}, {22'd0, v.exp_idx});
      chk($sformatf("v%0d_wdata", i), dccm_wdata, v.exp_wdata);
    end
    if (!v.we) lsu_q.push_back('{v.exp_rdata, v.tag, cyc + 1});
    part = v.we && v.be != 4'hF && v.be != 4'h0;
    @(posedge clk); #1 lsu_req_valid = 1'b0;
    if (part) begin
      @(negedge clk);
      chk($sformatf("v%0d_rmw_wen", i), {31'd0, dccm_wen}, 32'd1);
      chk($sformatf("v%0d_rmw_waddr", i), {22'd0, dccm_waddr}, {22'd0, v.exp_idx});
      chk($sformatf("v%0d_rmw_wdata", i), dccm_wdata, v.exp_wdata);
      chk($sformatf("v%0d_rmw_rvalid_in", i), {31'd0, dccm_rvalid_in}, 32'd0);
      @(posedge clk); #1;
    end
    $display("txn %0d we=%0d addr=%h be=%h wdata=%h tag=%0d", i, v.we, v.addr, v.be, v.wdata, v.tag);
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
  endtask

  initial begin
    //          we    addr    be    wdata         tag   wen  rd   idx      exp_wdata     exp_rdata
    vecs[0]  = '{1'b1, 12'h010, 4'hF, 32'hDEADBEEF, 4'd0, 1'b1, 1'b0, 10'd4,    32'hDEADBEEF, 32'h0};
    vecs[1]  = '{1'b0, 12'h010, 4'h0, 32'h0,        4'd3, 1'b0, 1'b1, 10'd4,    32'h0,        32'hDEADBEEF};
    vecs[2]  = '{1'b1, 12'h020, 4'hF, 32'h11223344, 4'd0, 1'b1, 1'b0, 10'd8,    32'h11223344, 32'h0};
    vecs[3]  = '{1'b1, 12'h020, 4'h2, 32'h0000AB00, 4'd0, 1'b0, 1'b1, 10'd8,    32'h1122AB44, 32'h0};
    vecs[4]  = '{1'b0, 12'h020, 4'h0, 32'h0,        4'd5, 1'b0, 1'b1, 10'd8,    32'h0,        32'h1122AB44};
    vecs[5]  = '{1'b1, 12'h010, 4'h0, 32'hFFFFFFFF, 4'd0, 1'b0, 1'b0, 10'd4,    32'h0,        32'h0};
    vecs[6]  = '{1'b0, 12'h013, 4'h0, 32'h0,        4'd7, 1'b0, 1'b1, 10'd4,    32'h0,        32'hDEADBEEF};
    vecs[7]  = '{1'b1, 12'h011, 4'h9, 32'hAA0000BB, 4'd0, 1'b0, 1'b1, 10'd4,    32'hAAADBEBB, 32'h0};
    vecs[8]  = '{1'b0, 12'h012, 4'h0, 32'h0,        4'hF, 1'b0, 1'b1, 10'd4,    32'h0,        32'hAAADBEBB};
    vecs[9]  = '{1'b1, 12'hFFC, 4'hF, 32'h5A5A5A5A, 4'd0, 1'b1, 1'b0, 10'd1023, 32'h5A5A5A5A, 32'h0};
    vecs[10] = '{1'b0, 12'hFFF, 4'h0, 32'h0,        4'd1, 1'b0, 1'b1, 10'd1023, 32'h0,        32'h5A5A5A5A};

    // Reset with both requesters valid: every output must be 0.
    rst = 1'b1;
    lsu_req_valid = 1'b1; lsu_req_we = 1'b0; lsu_req_addr = 12'h010;
    lsu_req_be = 4'h0; lsu_req_wdata = 32'h0; lsu_req_tag = 4'd0;
    dma_req_valid = 1'b1; dma_req_we = 1'b0; dma_req_addr = 12'h020;
    dma_req_be = 4'h0; dma_req_wdata = 32'h0; dma_req_tag = 4'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_lsu_ready", {31'd0, lsu_req_ready}, 32'd0);
    chk("reset_all_outputs", {31'd0, any_out}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; lsu_req_valid = 1'b0; dma_req_valid = 1'b0;

    for (int i = 0; i < 11; i++) do_txn(i, vecs[i]);
    repeat (2) @(posedge clk);
    #1;

`ifdef DCCM_CTRL_DMA_EN
    // Conflict from reset: grants alternate LSU, DMA, LSU, DMA.
    do_reset();
    lsu_req_valid = 1'b1; lsu_req_we = 1'b0; lsu_req_addr = 12'h010; lsu_req_tag = 4'd6;
    dma_req_valid = 1'b1; dma_req_we = 1'b0; dma_req_addr = 12'h020; dma_req_tag = 4'd9;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      chk($sformatf("conf%0d_lsu_ready", c), {31'd0, lsu_req_ready}, {31'd0, (c % 4) == 0});
      chk($sformatf("conf%0d_dma_ready", c), {31'd0, dma_req_ready}, {31'd0, (c % 4) == 2});
      if (lsu_req_ready) lsu_q.push_back('{32'hAAADBEBB, 4'd6, cyc + 1});
      if (dma_req_ready) dma_q.push_back('{32'h1122AB44, 4'd9, cyc + 1});
      $display("conflict cycle %0d lsu_ready=%0d dma_ready=%0d", c, lsu_req_ready, dma_req_ready);
      @(posedge clk); #1;
    end
    lsu_req_valid = 1'b0; dma_req_valid = 1'b0;
`else
    // DMA disabled: DMA valid held high is ignored; LSU loads every other cycle.
    do_reset();
    lsu_req_valid = 1'b1; lsu_req_we = 1'b0; lsu_req_addr = 12'h010; lsu_req_tag = 4'd6;
    dma_req_valid = 1'b1; dma_req_we = 1'b0; dma_req_addr = 12'h020; dma_req_tag = 4'd9;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk($sformatf("nodma%0d_lsu_ready", c), {31'd0, lsu_req_ready}, {31'd0, (c % 2) == 0});
      chk($sformatf("nodma%0d_dma_ready", c), {31'd0, dma_req_ready}, 32'd0);
      if (lsu_req_ready) lsu_q.push_back('{32'hAAADBEBB, 4'd6, cyc + 1});
      $display("nodma cycle %0d lsu_ready=%0d dma_ready=%0d", c, lsu_req_ready, dma_req_ready);
      @(posedge clk); #1;
    end
    lsu_req_valid = 1'b0; dma_req_valid = 1'b0;
`endif
    @(posedge clk); #1;

    // Reset during the RMW cycle aborts the write.
    lsu_req_we = 1'b1; lsu_req_addr = 12'h020; lsu_req_be = 4'h1;
    lsu_req_wdata = 32'h000000CC; lsu_req_valid = 1'b1;
    @(negedge clk);
    chk("rmwrst_ready", {31'd0, lsu_req_ready}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    lsu_req_we = 1'b0; lsu_req_tag = 4'd4;  // a load waits through reset
    @(negedge clk);
    chk("rmwrst_wen", {31'd0, dccm_wen}, 32'd0);
    chk("rmwrst_all_outputs", {31'd0, any_out}, 32'd0);
    $display("txn rmw-reset abort wen=%0d", dccm_wen);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("postrst_ready", {31'd0, lsu_req_ready}, 32'd1);
    chk("postrst_raddr", {22'd0, dccm_raddr}, 32'd8);
    if (lsu_req_ready) lsu_q.push_back('{32'h1122AB44, 4'd4, cyc + 1});
    $display("txn post-reset load addr=020 tag=4");
    @(posedge clk); #1 lsu_req_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);

    chk("lsu_q_drained", lsu_q.size(), 32'd0);
    chk("dma_q_drained", dma_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global watchdog so the bench always ends.
  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/dccm_ctrl.md
# dccm_ctrl

Request controller in front of the `dccm` data memory. It arbitrates between the load/store unit (LSU) and a DMA requester with round-robin priority. It turns byte-addressed requests into DCCM word accesses and performs sub-word stores as a two-cycle read-modify-write. It sits between the LSU/DMA and the single-read, single-write DCCM macro, and is the only block that drives the DCCM ports.

## Interface
Parameters:
- `WIDTH`, 32, DCCM word width in bits; a multiple of 8.
- `DEPTH`, 1024, DCCM depth in words.
- `TAG_W`, 4, request/response tag width.

Ports (`AW` = `$clog2(DEPTH*WIDTH/8)`, `BW` = `WIDTH/8`):
- `clk`  in  1  clock.
- `rst`  in  1  reset; asynchronous, active-high.
- `lsu_req_valid`  in  1  LSU request valid.
- `lsu_req_ready`  out  1  LSU request accepted this cycle.
- `lsu_req_we`  in  1  1 = store, 0 = load.
- `lsu_req_addr`  in  AW  byte address; low `$clog2(BW)` bits are ignored.
- `lsu_req_be`  in  BW  store byte enables.
- `lsu_req_wdata`  in  WIDTH  store data, lane-aligned.
- `lsu_req_tag`  in  TAG_W  load tag.
- `lsu_rsp_valid`  out  1  load data valid.
- `lsu_rsp_data`  out  WIDTH  load data.
- `lsu_rsp_tag`  out  TAG_W  tag of the returned load.
- `dma_*`  same set of 10 ports as `lsu_*`, same directions and widths.
- `dccm_raddr`  out  `$clog2(DEPTH)`  DCCM read word index.
- `dccm_rvalid_in`  out  1  DCCM read enable.
- `dccm_rdata`  in  WIDTH  DCCM read data (one cycle after the read).
- `dccm_rvalid_out`  in  1  DCCM read data valid.
- `dccm_waddr`  out  `$clog2(DEPTH)`  DCCM write word index.
- `dccm_wen`  out  1  DCCM write enable.
- `dccm_wdata`  out  WIDTH  DCCM write data.

## Operation
- FSM states:
  - IDLE: accepts requests.
  - RD: a load read is in flight.
  - RMW: a partial-store read is in flight.
- Arbitration happens in IDLE only:
  - If exactly one requester is valid, that requester is granted.
  - If both are valid, the requester not granted last time wins.
  - The last-granted pointer resets to DMA, so the LSU wins the first conflict.
- `x_req_ready` = IDLE & grant to x. Ready may depend on valid. A requester must not wait for ready before asserting valid. Valid and request fields must be held until the handshake.
- Word index = `addr[AW-1:$clog2(BW)]`.
- Load:
  - Handshake cycle: `dccm_rvalid_in`=1 and `dccm_raddr` = word index. The tag and requester ID are captured; state goes to RD.
  - RD: the owning requester sees `rsp_valid` = `dccm_rvalid_out`, `rsp_data` = `dccm_rdata`, `rsp_tag` = captured tag. State returns to IDLE.
- Full store (`be` all ones):
  - Handshake cycle: `dccm_wen`=1 with `waddr`/`wdata` driven directly from the request. State stays in IDLE.
  - Stores are posted; no response is returned.
- Partial store (`be` neither all ones nor zero):
  - Handshake cycle: DCCM read issued; address, `be` and `wdata` captured; state goes to RMW.
  - RMW: `dccm_wen`=1. Merged word = byte k from the captured `wdata` if `be[k]`, else byte k of `dccm_rdata`. State returns to IDLE.
- Store with `be`=0: accepted and dropped; no DCCM activity.
- The non-granted requester sees ready=0 and keeps its request.
- Responses go only to the requester that issued the load. The other requester's `rsp_valid` stays 0.

## Timing
- Reset values:
  - State IDLE; pointer = DMA; captured registers 0.
  - While `rst`=1, all outputs are 0, including readies.
- Load latency: response in the cycle after the handshake. Occupancy is 2 cycles, so back-to-back loads are accepted every other cycle.
- Full store: 1 cycle; a new request can be accepted the next cycle.
- Partial store: 2 cycles; DCCM write happens in the second cycle.
- Read-after-write: a load accepted the cycle after a store reads the new data, because the DCCM writes at the clock edge. No forwarding is needed.
- Reset asserted mid-operation (RD or RMW) aborts immediately: no response, no RMW write, state IDLE.
- `dccm_rvalid_in` and `dccm_wen` are never both asserted for the same requester in the same cycle.

## Configuration
- `DCCM_CTRL_DMA_EN` defined:
  - The DMA port is live and round-robin arbitration applies.
- `DCCM_CTRL_DMA_EN` undefined:
  - `dma_req_valid` is ignored.
  - All `dma_*` outputs are tied to 0.
  - The LSU is always granted in IDLE; the arbitration pointer is not built.

## Test plan
- Full-word store then load: LSU store addr 0x10, be 0xF, data 0xDEADBEEF; LSU load addr 0x10, tag 3 -> `dccm_wen` in cycle 0; `lsu_rsp_valid` 1 cycle after the load handshake with data 0xDEADBEEF, tag 3.
- Partial store: word 0x20 holds 0x11223344; store be 0x2, data 0x0000AB00 -> ready low for 1 cycle; `dccm_wen` in the second cycle with wdata 0x1122AB44.
- Conflict: both LSU and DMA valid continuously with loads from reset -> grants go LSU, DMA, LSU, DMA; each response carries its own tag on its own port only.
- Zero byte enables and unaligned address: store be 0 -> no `dccm_wen` or `dccm_rvalid_in`, ready=1; load addr 0x13 -> `dccm_raddr` = 4.
- Reset mid-RMW: assert `rst` in the RMW cycle -> no `dccm_wen`, all outputs 0; after release, a new LSU load is accepted in IDLE.
- Build without `DCCM_CTRL_DMA_EN`: DMA valid held high -> `dma_req_ready` stays 0; LSU is served every eligible cycle.
